nios_system_status_in: RTL and testbench

//  Avalon-MM slave input port: the read-side counterpart of the command output PIO.

---
 rtl/nios_pio_pkg.sv | 12 +
 rtl/pio_sync_edge.sv | 45 ++++
 rtl/nios_system_status_in.sv | 59 +++++
 tb/tb_nios_system_status_in.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/nios_pio_pkg.sv
// nios_pio_pkg: register map and edge-type constants shared by the status input PIO.
package nios_pio_pkg;
  typedef enum logic [1:0] {
    ADDR_DATA   = 2'd0,
    ADDR_RSVD   = 2'd1,
    ADDR_IRQMSK = 2'd2,
    ADDR_EDGE   = 2'd3
  } addr_e;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/pio_sync_edge.sv
// pio_sync_edge: synchronises async inputs into clk and emits per-bit edge pulses.
module pio_sync_edge
  import nios_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] edge_out
);
  localparam int PW = $clog2(SYNC_STAGES + 2);
  localparam logic [PW-1:0] PRIME_DONE = PW'(SYNC_STAGES + 1);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d, rise, fall;
  logic [PW-1:0] prime_q, prime_d;
  logic primed;
  // Primed only once the chain and prev hold real samples, so inputs high at reset never look like edges.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], in_port};
    sync_out = sync_q[SYNC_STAGES-1];
    prev_d   = sync_out;
    primed   = prime_q == PRIME_DONE;
    prime_d  = primed ? prime_q : prime_q + PW'(1);
    rise     = sync_out & ~prev_q;
    fall     = ~sync_out & prev_q;
    edge_out = !primed ? '0 :
               EDGE_TYPE == EDGE_RISE ? rise :
               EDGE_TYPE == EDGE_FALL ? fall : (rise | fall);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      prev_q  <= '0;
      prime_q <= '0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      prime_q <= prime_d;
    end
  end
endmodule

// File: rtl/nios_system_status_in.sv
// nios_system_status_in: Avalon-MM status input PIO with edge capture and maskable level IRQ.
// PIO_BIT_CLEAR_EN: EDGE writes clear only the bits set in writedata; otherwise any EDGE write clears all.
module nios_system_status_in
  import nios_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] sync_val, edge_pulse, clr_bits, rd_val;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d, edge_cap_q, edge_cap_d;
  logic irq_q, irq_d, wr, unused_ok;
  pio_sync_edge #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .EDGE_TYPE(EDGE_TYPE)) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .sync_out (sync_val),
    .edge_out (edge_pulse)
  );
`ifdef PIO_BIT_CLEAR_EN
  assign clr_bits = writedata[WIDTH-1:0];
`else
  assign clr_bits = '1;
`endif
  assign unused_ok = ^writedata;
  // New edges are OR-ed in after the clear so a same-cycle event always survives.
  always_comb begin
    wr         = chipselect & ~write_n;
    irq_mask_d = (wr && address == ADDR_IRQMSK) ? writedata[WIDTH-1:0] : irq_mask_q;
    edge_cap_d = (edge_cap_q & ~((wr && address == ADDR_EDGE) ? clr_bits : '0)) | edge_pulse;
    irq_d      = |(edge_cap_q & irq_mask_q);
    rd_val     = address == ADDR_DATA   ? sync_val   :
                 address == ADDR_IRQMSK ? irq_mask_q :
                 address == ADDR_EDGE   ? edge_cap_q : '0;
    readdata   = 32'(rd_val);
    irq        = irq_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      irq_q      <= irq_d;
    end
  end
endmodule

// File: tb/tb_nios_system_status_in.sv
// tb_nios_system_status_in: directed self-checking bench for the status input PIO.
module tb_nios_system_status_in;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata;
  logic        irq;
  int checks = 0;
  int errors = 0;

  nios_system_status_in #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 8'hFF;
    cycles(3);
    rd(2'd0, "reset_data", 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    // Inputs high through reset: DATA appears after two clocks, no edge captured.
    @(negedge clk); reset_n = 1'b1;
    cycles(1);
    rd(2'd0, "data_lat1", 32'h0);
    cycles(1);
    rd(2'd0, "data_lat2", 32'hFF);
    cycles(8);
    rd(2'd3, "edge_after_reset", 32'h0);
    chk("irq_after_reset", {31'b0, irq}, 32'h0);
    // Falling edges ignored, rising edge on bit 0 captured and raises irq.
    @(negedge clk); in_port = 8'h00;
    cycles(5);
    rd(2'd3, "edge_fall_ignored", 32'h0);
    @(negedge clk); wr(2'd2, 32'h01);
    rd(2'd2, "irqmsk_rd", 32'h01);
    @(negedge clk); in_port = 8'h01;
    cycles(3);
    rd(2'd3, "edge_bit0", 32'h01);
    chk("irq_pre", {31'b0, irq}, 32'h0);
    cycles(1);
    chk("irq_bit0", {31'b0, irq}, 32'h1);
    @(negedge clk); wr(2'd3, 32'h01);
    rd(2'd3, "edge_cleared", 32'h0);
    chk("irq_still_reg", {31'b0, irq}, 32'h1);
    cycles(1);
    chk("irq_dropped", {31'b0, irq}, 32'h0);
    // Masked capture, then unmask.
    @(negedge clk); wr(2'd2, 32'h00);
    in_port = 8'h09;
    cycles(4);
    rd(2'd3, "edge_bit3", 32'h08);
    chk("irq_masked", {31'b0, irq}, 32'h0);
    @(negedge clk); wr(2'd2, 32'h08);
    chk("irq_unmask_lat", {31'b0, irq}, 32'h0);
    cycles(1);
    chk("irq_unmasked", {31'b0, irq}, 32'h1);
    @(negedge clk); wr(2'd2, 32'h00);
    cycles(1);
    chk("irq_remask", {31'b0, irq}, 32'h0);
    rd(2'd3, "edge_kept_masked", 32'h08);
    @(negedge clk); wr(2'd3, 32'hFF);
    rd(2'd3, "edge_clr_all", 32'h0);
    // Bit 2 edge captured on the same clock as a clear write of bit 2.
    @(negedge clk); in_port = 8'h0D;
    cycles(2);
    wr(2'd3, 32'h04);
    rd(2'd3, "collision", 32'h04);
    // Partial clear behaviour depends on the build option.
    @(negedge clk); in_port = 8'h05;
    cycles(4);
    in_port = 8'h0D;
    cycles(4);
    rd(2'd3, "edge_0c", 32'h0C);
    @(negedge clk); wr(2'd3, 32'h04);
`ifdef PIO_BIT_CLEAR_EN
    rd(2'd3, "edge_partial_clr", 32'h08);
`else
    rd(2'd3, "edge_partial_clr", 32'h00);
`endif
    // Writes to read-only addresses have no effect.
    @(negedge clk); wr(2'd2, 32'h08);
    wr(2'd0, 32'hDEAD);
    wr(2'd1, 32'hDEAD);
    rd(2'd0, "data_ro", 32'h0D);
    rd(2'd1, "rsvd_ro", 32'h0);
    rd(2'd2, "irqmsk_unchanged", 32'h08);
    // Reset mid-capture clears everything asynchronously.
    @(negedge clk); wr(2'd2, 32'hFF);
    in_port = 8'h0F;
    cycles(5);
    chk("irq_before_rst", {31'b0, irq}, 32'h1);
    #2 reset_n = 1'b0;
    rd(2'd3, "rst_edge", 32'h0);
    rd(2'd2, "rst_irqmsk", 32'h0);
    rd(2'd0, "rst_data", 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk); reset_n = 1'b1;
    cycles(10);
    rd(2'd3, "edge_reprime", 32'h0);
    rd(2'd0, "data_reprime", 32'h0F);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
